param_memory: RTL and testbench

//  Parametrised single-port bench memory model, successor to the fixed 256x8 store.

---
 rtl/param_memory.sv | 220 ++++++++++++++++++++++
 tb/tb_param_memory.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_memory.sv
// Parametrised single-port memory model with valid/ready requests, bit-masked writes, FILL init/clear sweep and 1- or 2-cycle read latency.
// Optional MEM_PARITY_EN macro adds a per-word even-parity bit, a par_inject port and live rsp_perr reporting.
module param_memory #(
   parameter int                DATA_W = 8,
   parameter int                ADDR_W = 8,
   parameter int                DEPTH  = 256,
   parameter logic [DATA_W-1:0] FILL   = {DATA_W{1'b1}},
   parameter int                RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   output logic              init_busy,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [DATA_W-1:0] req_wmask,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_perr
`ifdef MEM_PARITY_EN
   ,
   input  logic              par_inject
`endif
);

   // Handshake: a request transfers on a rising clk edge where req_valid && req_ready;
   // req_ready drops combinationally with clear, and responses cannot be back-pressured.

   localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

   typedef enum logic {ST_INIT, ST_READY} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              init_busy_q, init_busy_d;
   logic              sweep_we;

   logic [DATA_W-1:0] mem [DEPTH];
`ifdef MEM_PARITY_EN
   logic              par_mem [DEPTH];
`endif

   logic              fire;
   logic              in_range;
   logic [IDX_W-1:0]  req_idx;
   logic [DATA_W-1:0] old_word;
   logic [DATA_W-1:0] merged_word;

   logic              mem_we;
   logic [IDX_W-1:0]  mem_widx;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_wpar;

   logic              acc_valid;
   logic [DATA_W-1:0] acc_data;
   logic              acc_err;
   logic              acc_perr;

   logic              p1_valid_q, p1_valid_d;
   logic [DATA_W-1:0] p1_data_q, p1_data_d;
   logic              p1_err_q, p1_err_d;
   logic              p1_perr_q, p1_perr_d;

   logic              src_valid;
   logic [DATA_W-1:0] src_data;
   logic              src_err;
   logic              src_perr;

   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;
   logic              rsp_perr_q, rsp_perr_d;

   // Sweep sequencer: INIT writes FILL at ptr every cycle, clear restarts it from word 0.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      sweep_we = 1'b0;
      case (state_q)
         ST_INIT: begin
            sweep_we = 1'b1;
            if (clear) begin
               ptr_d = '0;
            end else if (ptr_q == LAST_C) begin
               state_d = ST_READY;
               ptr_d   = '0;
            end else begin
               ptr_d = ptr_q + ADDR_W'(1);
            end
         end
         ST_READY: begin
            if (clear) begin
               state_d = ST_INIT;
               ptr_d   = '0;
            end
         end
         default: begin
            state_d = ST_INIT;
            ptr_d   = '0;
         end
      endcase
      init_busy_d = (state_d == ST_INIT);
   end

   assign req_ready = (state_q == ST_READY) && !clear;
   assign fire      = req_valid && req_ready;
   assign req_idx   = req_addr[IDX_W-1:0];
   assign in_range  = ({1'b0, req_addr} < DEPTH_C);

   always_comb begin
      old_word    = mem[req_idx];
      merged_word = (req_wdata & req_wmask) | (old_word & ~req_wmask);
   end

   // Single write port shared by the sweep and accepted in-range writes; they never overlap.
   always_comb begin
      mem_we    = 1'b0;
      mem_widx  = ptr_q[IDX_W-1:0];
      mem_wdata = FILL;
      mem_wpar  = ^FILL;
      if (sweep_we) begin
         mem_we = 1'b1;
      end else if (fire && req_wr && in_range) begin
         mem_we    = 1'b1;
         mem_widx  = req_idx;
         mem_wdata = merged_word;
`ifdef MEM_PARITY_EN
         mem_wpar  = (^merged_word) ^ par_inject;
`else
         mem_wpar  = ^merged_word;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_widx] <= mem_wdata;
`ifdef MEM_PARITY_EN
         par_mem[mem_widx] <= mem_wpar;
`endif
      end
   end

   // Read data is captured at accept, so a later clear sweep cannot disturb it.
   always_comb begin
      acc_valid = fire && !req_wr;
      acc_data  = in_range ? old_word : FILL;
      acc_err   = !in_range;
`ifdef MEM_PARITY_EN
      acc_perr  = in_range && (par_mem[req_idx] != (^old_word));
`else
      acc_perr  = 1'b0;
`endif
   end

   always_comb begin
      p1_valid_d = acc_valid;
      p1_data_d  = acc_valid ? acc_data : p1_data_q;
      p1_err_d   = acc_valid && acc_err;
      p1_perr_d  = acc_valid && acc_perr;

      if (RD_LAT >= 2) begin
         src_valid = p1_valid_q;
         src_data  = p1_data_q;
         src_err   = p1_err_q;
         src_perr  = p1_perr_q;
      end else begin
         src_valid = acc_valid;
         src_data  = acc_data;
         src_err   = acc_err;
         src_perr  = acc_perr;
      end

      rsp_valid_d = src_valid;
      rsp_rdata_d = src_valid ? src_data : rsp_rdata_q;
      rsp_err_d   = src_valid && src_err;
      rsp_perr_d  = src_valid && src_perr;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_INIT;
         ptr_q       <= '0;
         init_busy_q <= 1'b1;
         p1_valid_q  <= 1'b0;
         p1_data_q   <= FILL;
         p1_err_q    <= 1'b0;
         p1_perr_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= FILL;
         rsp_err_q   <= 1'b0;
         rsp_perr_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         init_busy_q <= init_busy_d;
         p1_valid_q  <= p1_valid_d;
         p1_data_q   <= p1_data_d;
         p1_err_q    <= p1_err_d;
         p1_perr_q   <= p1_perr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         rsp_perr_q  <= rsp_perr_d;
      end
   end

   assign init_busy = init_busy_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_perr  = rsp_perr_q;

endmodule

// File: tb/tb_param_memory.sv
// Directed bench for param_memory: three instances (RD_LAT=1, RD_LAT=2, DEPTH=200) share one request stream.
module tb_param_memory;

   logic       clk = 1'b0;
   logic       reset;
   logic       clear;
   logic       req_valid;
   logic       req_wr;
   logic [7:0] req_addr;
   logic [7:0] req_wdata;
   logic [7:0] req_wmask;
`ifdef MEM_PARITY_EN
   logic       par_inject;
`endif

   logic       busy_a, ready_a, rv_a, re_a, rp_a;
   logic [7:0] rd_a;
   logic       busy_b, ready_b, rv_b, re_b, rp_b;
   logic [7:0] rd_b;
   logic       busy_c, ready_c, rv_c, re_c, rp_c;
   logic [7:0] rd_c;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   param_memory #(.RD_LAT(1)) dut_a (
      .clk(clk), .reset(reset), .clear(clear), .init_busy(busy_a),
      .req_valid(req_valid), .req_ready(ready_a), .req_wr(req_wr), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_wmask(req_wmask), .rsp_valid(rv_a), .rsp_rdata(rd_a),
      .rsp_err(re_a), .rsp_perr(rp_a)
`ifdef MEM_PARITY_EN
      , .par_inject(par_inject)
`endif
   );

   param_memory #(.RD_LAT(2)) dut_b (
      .clk(clk), .reset(reset), .clear(clear), .init_busy(busy_b),
      .req_valid(req_valid), .req_ready(ready_b), .req_wr(req_wr), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_wmask(req_wmask), .rsp_valid(rv_b), .rsp_rdata(rd_b),
      .rsp_err(re_b), .rsp_perr(rp_b)
`ifdef MEM_PARITY_EN
      , .par_inject(par_inject)
`endif
   );

   param_memory #(.DEPTH(200)) dut_c (
      .clk(clk), .reset(reset), .clear(clear), .init_busy(busy_c),
      .req_valid(req_valid), .req_ready(ready_c), .req_wr(req_wr), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_wmask(req_wmask), .rsp_valid(rv_c), .rsp_rdata(rd_c),
      .rsp_err(re_c), .rsp_perr(rp_c)
`ifdef MEM_PARITY_EN
      , .par_inject(par_inject)
`endif
   );

   // Presents one request and returns 1 time unit after the edge that accepted it.
   task automatic issue(input logic wr, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] m, input logic inj);
      int guard;
      req_valid = 1'b1;
      req_wr    = wr;
      req_addr  = a;
      req_wdata = d;
      req_wmask = m;
`ifdef MEM_PARITY_EN
      par_inject = inj;
`else
      if (inj) $display("note: par_inject ignored in this build");
`endif
      guard = 0;
      while (ready_a !== 1'b1 && guard < 1000) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 1000) begin
         total++; bad++;
         $display("FAIL issue_timeout addr=%h ready=%b", a, ready_a);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_wr    = 1'b0;
`ifdef MEM_PARITY_EN
      par_inject = 1'b0;
`endif
   endtask

   task automatic wait_init(input string name);
      int guard;
      guard = 0;
      while ((busy_a || busy_b || busy_c) && guard < 1000) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 1000) begin
         total++; bad++;
         $display("FAIL %s_init_timeout busy=%b%b%b", name, busy_a, busy_b, busy_c);
      end
   endtask

   task automatic test_reset();
      int cnt_a, cnt_c, rdy_cnt;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL rst_busy got=%b exp=1", busy_a); end
      total++; if (ready_a !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", ready_a); end
      total++; if (rv_a !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", rv_a); end
      total++; if (rd_a !== 8'hFF) begin bad++; $display("FAIL rst_rdata got=%h exp=ff", rd_a); end
      total++; if (re_a !== 1'b0 || rp_a !== 1'b0) begin bad++; $display("FAIL rst_err got=%b%b exp=00", re_a, rp_a); end
      reset = 1'b0;
      cnt_a = 0; cnt_c = 0; rdy_cnt = 0;
      for (int i = 0; i < 300; i++) begin
         if (busy_a) cnt_a++;
         if (busy_c) cnt_c++;
         if (busy_a && ready_a) rdy_cnt++;
         @(posedge clk); #1;
      end
      total++; if (cnt_a !== 256) begin bad++; $display("FAIL init_cycles got=%0d exp=256", cnt_a); end
      total++; if (cnt_c !== 200) begin bad++; $display("FAIL init_cycles_d200 got=%0d exp=200", cnt_c); end
      total++; if (rdy_cnt !== 0) begin bad++; $display("FAIL init_ready got=%0d exp=0", rdy_cnt); end
      total++; if (ready_a !== 1'b1) begin bad++; $display("FAIL ready_after_init got=%b exp=1", ready_a); end
      issue(1'b0, 8'h10, 8'h00, 8'h00, 1'b0);
      total++; if (rv_a !== 1'b1) begin bad++; $display("FAIL init_rd_valid got=%b exp=1", rv_a); end
      total++; if (rd_a !== 8'hFF) begin bad++; $display("FAIL init_rd_data got=%h exp=ff", rd_a); end
      total++; if (re_a !== 1'b0) begin bad++; $display("FAIL init_rd_err got=%b exp=0", re_a); end
      @(posedge clk); #1;
   endtask

   task automatic test_write_read();
      issue(1'b1, 8'h3C, 8'hA5, 8'hFF, 1'b0);
      issue(1'b0, 8'h3C, 8'h00, 8'h00, 1'b0);
      total++; if (rv_a !== 1'b1) begin bad++; $display("FAIL wr_rd_lat1_valid got=%b exp=1", rv_a); end
      total++; if (rd_a !== 8'hA5) begin bad++; $display("FAIL wr_rd_lat1_data got=%h exp=a5", rd_a); end
      total++; if (rv_b !== 1'b0) begin bad++; $display("FAIL wr_rd_lat2_early got=%b exp=0", rv_b); end
      @(posedge clk); #1;
      total++; if (rv_b !== 1'b1) begin bad++; $display("FAIL wr_rd_lat2_valid got=%b exp=1", rv_b); end
      total++; if (rd_b !== 8'hA5) begin bad++; $display("FAIL wr_rd_lat2_data got=%h exp=a5", rd_b); end
      total++; if (rv_a !== 1'b0) begin bad++; $display("FAIL wr_rd_lat1_pulse got=%b exp=0", rv_a); end
   endtask

   task automatic test_masked_write();
      issue(1'b1, 8'h01, 8'h00, 8'hFF, 1'b0);
      issue(1'b1, 8'h01, 8'hF0, 8'h3C, 1'b0);
      issue(1'b0, 8'h01, 8'h00, 8'h00, 1'b0);
      total++; if (rd_a !== 8'h30) begin bad++; $display("FAIL mask_data got=%h exp=30", rd_a); end
      @(posedge clk); #1;
      issue(1'b1, 8'h01, 8'h12, 8'h00, 1'b0);
      issue(1'b0, 8'h01, 8'h00, 8'h00, 1'b0);
      total++; if (rv_a !== 1'b1 || rd_a !== 8'h30) begin bad++; $display("FAIL mask_zero got=%b/%h exp=1/30", rv_a, rd_a); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      issue(1'b1, 8'h20, 8'h11, 8'hFF, 1'b0);
      issue(1'b1, 8'h21, 8'h22, 8'hFF, 1'b0);
      req_valid = 1'b1; req_wr = 1'b0; req_addr = 8'h20;
      total++; if (ready_a !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b exp=1", ready_a); end
      @(posedge clk); #1;
      req_addr = 8'h21;
      total++; if (rv_a !== 1'b1 || rd_a !== 8'h11) begin bad++; $display("FAIL b2b_a0 got=%b/%h exp=1/11", rv_a, rd_a); end
      @(posedge clk); #1;
      req_valid = 1'b0;
      total++; if (rv_a !== 1'b1 || rd_a !== 8'h22) begin bad++; $display("FAIL b2b_a1 got=%b/%h exp=1/22", rv_a, rd_a); end
      total++; if (rv_b !== 1'b1 || rd_b !== 8'h11) begin bad++; $display("FAIL b2b_b0 got=%b/%h exp=1/11", rv_b, rd_b); end
      @(posedge clk); #1;
      total++; if (rv_a !== 1'b0 || rd_a !== 8'h22) begin bad++; $display("FAIL b2b_a_hold got=%b/%h exp=0/22", rv_a, rd_a); end
      total++; if (rv_b !== 1'b1 || rd_b !== 8'h22) begin bad++; $display("FAIL b2b_b1 got=%b/%h exp=1/22", rv_b, rd_b); end
      @(posedge clk); #1;
      total++; if (rv_b !== 1'b0 || rd_b !== 8'h22) begin bad++; $display("FAIL b2b_b_hold got=%b/%h exp=0/22", rv_b, rd_b); end
   endtask

   task automatic test_range();
      issue(1'b1, 8'hC8, 8'h55, 8'hFF, 1'b0);
      issue(1'b0, 8'hC8, 8'h00, 8'h00, 1'b0);
      total++; if (rv_c !== 1'b1 || re_c !== 1'b1) begin bad++; $display("FAIL range_err got=%b/%b exp=1/1", rv_c, re_c); end
      total++; if (rd_c !== 8'hFF) begin bad++; $display("FAIL range_data got=%h exp=ff", rd_c); end
      total++; if (rd_a !== 8'h55 || re_a !== 1'b0) begin bad++; $display("FAIL range_full got=%h/%b exp=55/0", rd_a, re_a); end
      @(posedge clk); #1;
      issue(1'b0, 8'hC7, 8'h00, 8'h00, 1'b0);
      total++; if (rv_c !== 1'b1 || re_c !== 1'b0) begin bad++; $display("FAIL range_last got=%b/%b exp=1/0", rv_c, re_c); end
      @(posedge clk); #1;
   endtask

   task automatic test_clear();
      int cnt, rdy, guard;
      for (int i = 0; i < 16; i++) begin
         logic [7:0] a, d;
         a = 8'(i);
         d = 8'(8'h40 + i);
         issue(1'b1, a, d, 8'hFF, 1'b0);
      end
      issue(1'b0, 8'h05, 8'h00, 8'h00, 1'b0);
      clear = 1'b1;
      #1;
      total++; if (rv_a !== 1'b1 || rd_a !== 8'h45) begin bad++; $display("FAIL clr_old_a got=%b/%h exp=1/45", rv_a, rd_a); end
      total++; if (ready_a !== 1'b0) begin bad++; $display("FAIL clr_ready_now got=%b exp=0", ready_a); end
      @(posedge clk); #1;
      clear = 1'b0;
      total++; if (rv_b !== 1'b1 || rd_b !== 8'h45) begin bad++; $display("FAIL clr_old_b got=%b/%h exp=1/45", rv_b, rd_b); end
      cnt = 0; rdy = 0; guard = 0;
      while (busy_a && guard < 400) begin
         cnt++;
         if (ready_a) rdy++;
         @(posedge clk); #1;
         guard++;
      end
      total++; if (cnt !== 256) begin bad++; $display("FAIL clr_cycles got=%0d exp=256", cnt); end
      total++; if (rdy !== 0) begin bad++; $display("FAIL clr_ready got=%0d exp=0", rdy); end
      wait_init("clear");
      issue(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      total++; if (rd_a !== 8'hFF) begin bad++; $display("FAIL clr_rd00 got=%h exp=ff", rd_a); end
      issue(1'b0, 8'h05, 8'h00, 8'h00, 1'b0);
      total++; if (rd_a !== 8'hFF) begin bad++; $display("FAIL clr_rd05 got=%h exp=ff", rd_a); end
      issue(1'b0, 8'h0F, 8'h00, 8'h00, 1'b0);
      total++; if (rd_a !== 8'hFF) begin bad++; $display("FAIL clr_rd0f got=%h exp=ff", rd_a); end
      @(posedge clk); #1;
      total++; if (rv_b !== 1'b1 || rd_b !== 8'hFF) begin bad++; $display("FAIL clr_rd0f_b got=%b/%h exp=1/ff", rv_b, rd_b); end
   endtask

   task automatic test_reset_mid_read();
      issue(1'b1, 8'h3C, 8'hA5, 8'hFF, 1'b0);
      issue(1'b0, 8'h3C, 8'h00, 8'h00, 1'b0);
      reset = 1'b1;
      #1;
      total++; if (rv_a !== 1'b0) begin bad++; $display("FAIL rmid_a_valid got=%b exp=0", rv_a); end
      reset = 1'b0;
      @(posedge clk); #1;
      total++; if (rv_b !== 1'b0) begin bad++; $display("FAIL rmid_b_valid got=%b exp=0", rv_b); end
      total++; if (rd_b !== 8'hFF) begin bad++; $display("FAIL rmid_b_data got=%h exp=ff", rd_b); end
      total++; if (busy_b !== 1'b1) begin bad++; $display("FAIL rmid_busy got=%b exp=1", busy_b); end
      @(posedge clk); #1;
      total++; if (rv_b !== 1'b0) begin bad++; $display("FAIL rmid_b_late got=%b exp=0", rv_b); end
      wait_init("reset_mid");
   endtask

`ifdef MEM_PARITY_EN
   task automatic test_parity();
      issue(1'b1, 8'h30, 8'h3C, 8'hFF, 1'b1);
      issue(1'b0, 8'h30, 8'h00, 8'h00, 1'b0);
      total++; if (rv_a !== 1'b1 || rp_a !== 1'b1) begin bad++; $display("FAIL par_inject got=%b/%b exp=1/1", rv_a, rp_a); end
      total++; if (rd_a !== 8'h3C) begin bad++; $display("FAIL par_data got=%h exp=3c", rd_a); end
      @(posedge clk); #1;
      issue(1'b1, 8'h30, 8'h3C, 8'hFF, 1'b0);
      issue(1'b0, 8'h30, 8'h00, 8'h00, 1'b0);
      total++; if (rv_a !== 1'b1 || rp_a !== 1'b0) begin bad++; $display("FAIL par_clean got=%b/%b exp=1/0", rv_a, rp_a); end
      @(posedge clk); #1;
   endtask
`endif

   initial begin
      reset = 1'b1; clear = 1'b0; req_valid = 1'b0; req_wr = 1'b0;
      req_addr = 8'h00; req_wdata = 8'h00; req_wmask = 8'h00;
`ifdef MEM_PARITY_EN
      par_inject = 1'b0;
`endif
      test_reset();
      test_write_read();
      test_masked_write();
      test_back_to_back();
      test_range();
      test_clear();
      test_reset_mid_read();
`ifdef MEM_PARITY_EN
      test_parity();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
